// File: rtl/seg7_capture.sv
// seg7_capture
//   Watches a multiplexed, active-low 7-segment display bus and turns it back
//   into a hex word. Each digit must be seen unchanged for STABLE_CYCLES
//   registered samples before it is captured; once every digit has been
//   captured the assembled word is published with a one-cycle valid pulse.
//
// Parameters
//   NUM_DIGITS    number of multiplexed digits (>= 1)
//   STABLE_CYCLES identical consecutive samples needed to capture (>= 1)
//   CW            stability counter width (2**CW > STABLE_CYCLES)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   seg_n      in   segment lines, active-low, bit0=a .. bit6=g
//   dig_n      in   digit enables, active-low, bit i = digit i
//   value      out  last completed word, nibble i = digit i
//   valid      out  one-cycle pulse when value updates
//   err        out  one-cycle pulse with valid if any digit was undecodable
//   digit_bad  out  per-digit undecodable flags of the last completed frame
//
// Handshake: there is no back-pressure. valid is a single-cycle strobe;
// value/digit_bad are updated in that same cycle and held until the next
// strobe, so a consumer may sample them on valid or at any later time.

module seg7_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CW            = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                seg_n,
    input  logic [NUM_DIGITS-1:0]     dig_n,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic                      valid,
    output logic                      err,
    output logic [NUM_DIGITS-1:0]     digit_bad
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    state_t                    state;
    state_t                    state_n;
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             cnt_n;

    // Registered sample S and the sample from the cycle before it.
    logic [6:0]                seg_s;
    logic [6:0]                seg_p;
    logic [NUM_DIGITS-1:0]     dig_s;
    logic [NUM_DIGITS-1:0]     dig_p;

    logic [NUM_DIGITS-1:0]     mask;
    logic [4*NUM_DIGITS-1:0]   stage_val;
    logic [NUM_DIGITS-1:0]     stage_bad;

    int                        zeros;
    logic                      sel;
    logic                      changed;
    logic                      capture;
    logic                      full;
    logic [3:0]                dec_nib;
    logic                      dec_bad;

    // Selected means exactly one digit enable is low.
    always_comb begin
        zeros = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!dig_s[i]) zeros = zeros + 1;
        end
        sel = (zeros == 1);
    end

    assign changed = (seg_s != seg_p) || (dig_s != dig_p);
    assign full    = &mask;

    always_comb begin
        dec_nib = 4'h0;
        dec_bad = 1'b0;
        case (seg_s)
            7'b1000000: dec_nib = 4'h0;
            7'b1111001: dec_nib = 4'h1;
            7'b0100100: dec_nib = 4'h2;
            7'b0110000: dec_nib = 4'h3;
            7'b0011001: dec_nib = 4'h4;
            7'b0010010: dec_nib = 4'h5;
            7'b0000010: dec_nib = 4'h6;
            7'b1111000: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0011000: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b0000011: dec_nib = 4'hB;
            7'b1000110: dec_nib = 4'hC;
            7'b0100001: dec_nib = 4'hD;
            7'b0000110: dec_nib = 4'hE;
            7'b0001110: dec_nib = 4'hF;
            default: begin
                dec_nib = 4'h0;
                dec_bad = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (sel) begin
                    state_n = SETTLE;
                    cnt_n   = ONE;
                end
            end
            SETTLE: begin
                if (!sel) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (changed) begin
                    cnt_n = ONE;
                end else if (cnt < STABLE) begin
                    cnt_n = cnt + ONE;
                end
            end
            HELD: begin
                if (!sel) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (changed) begin
                    state_n = SETTLE;
                    cnt_n   = ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // Reaching the threshold captures in the same cycle, which also
        // covers STABLE_CYCLES=1 capturing on the first selected sample.
        if (state_n == SETTLE && cnt_n >= STABLE) begin
            capture = 1'b1;
            state_n = HELD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_s     <= '1;
            seg_p     <= '1;
            dig_s     <= '1;
            dig_p     <= '1;
            state     <= IDLE;
            cnt       <= '0;
            mask      <= '0;
            stage_val <= '0;
            stage_bad <= '0;
            value     <= '0;
            digit_bad <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
        end else begin
            seg_s <= seg_n;
            dig_s <= dig_n;
            seg_p <= seg_s;
            dig_p <= dig_s;
            state <= state_n;
            cnt   <= cnt_n;

            // A completed frame is published one cycle after the mask fills.
            valid <= full;
            err   <= full & (|stage_bad);
            if (full) begin
                value     <= stage_val;
                digit_bad <= stage_bad;
            end

            // ~dig_s is one-hot for the selected digit whenever capture is set;
            // a capture coinciding with completion starts the next frame.
            mask <= (full ? '0 : mask) | (capture ? ~dig_s : '0);

            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && !dig_s[i]) begin
                    stage_val[i*4 +: 4] <= dec_nib;
                    stage_bad[i]        <= dec_bad;
                end
            end
        end
    end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receive-side counterpart of the hex-to-7-segment encoder.
- Monitors a multiplexed, active-low 7-segment display bus (segment lines plus per-digit enables) and decodes each digit pattern back to its 4-bit hex value.
- Assembles a full multi-digit word and pulses a valid flag once every digit has been captured.
- Used as a self-check/loopback monitor on the display path and as a bench-side reader in system tests.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; at least 1.
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured; at least 1.
- CW, 8: stability counter width; 2^CW must exceed STABLE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- seg_n  in  7  segment lines, active-low; bit0=a … bit6=g
- dig_n  in  NUM_DIGITS  digit enables, active-low; bit i selects digit i (digit 0 = least significant nibble)
- value  out  4*NUM_DIGITS  last completed word; nibble i = digit i
- valid  out  1  one-cycle pulse when value updates
- err  out  1  one-cycle pulse, coincident with valid, if any digit in the frame was undecodable
- digit_bad  out  NUM_DIGITS  per-digit undecodable flags for the last completed frame; held until the next frame

Behaviour:
- Reset: value=0, valid=0, err=0, digit_bad=0. Internal state: capture mask=0, counter=0, state=IDLE, sample registers=all ones. Reset mid-frame discards all partial captures.
- Input stage: seg_n and dig_n are registered once, with no synchronizer (inputs are same-clock). All further logic uses the registered sample S.
- S is "selected" when exactly one dig_n bit is low. Zero or multiple low bits make S not selected.
- Decode table, seg_n[6:0] -> nibble:
  - 0: 1000000; 1: 1111001; 2: 0100100; 3: 0110000
  - 4: 0011001; 5: 0010010; 6: 0000010; 7: 1111000
  - 8: 0000000; 9: 0011000; A: 0001000; b: 0000011
  - C: 1000110; d: 0100001; E: 0000110; F: 0001110
  - Any other pattern, including blank 1111111, decodes to nibble 0 and marks the digit bad.
- State machine:
  - IDLE: S not selected. When S is selected, go to SETTLE with counter=1.
  - SETTLE: if S is unselected, go to IDLE with counter=0. If S differs from the previous sample, restart with counter=1. Otherwise increment the counter. When the counter reaches STABLE_CYCLES, capture and go to HELD. With STABLE_CYCLES=1, capture happens in the cycle the first selected sample is seen.
  - HELD: no recapture while S is unchanged. If S changes and is still selected, go to SETTLE with counter=1. If S is unselected, go to IDLE.
- Capture: writes the decoded nibble and bad bit into the per-digit staging registers for the selected digit, and sets that digit's mask bit. Recapturing a digit already in the mask overwrites it (latest wins).
- Frame completion: in the cycle after the capture that makes the mask all ones:
  - staging is copied to value and digit_bad;
  - valid=1, and err=1 if any staged bad bit is set;
  - the mask clears.
  - valid and err are high for exactly one cycle.
- Latency: the dig_n/seg_n edge that starts the last digit leads to valid high 1 + STABLE_CYCLES cycles later (register stage + settle + output register).
- A capture arriving in the same cycle as frame completion goes to the next frame: the mask clears and then sets that digit's bit.
- Counter saturates at STABLE_CYCLES and never wraps.
- value and digit_bad change only on frame completion or reset.

Test Plan:
- Reset, NUM_DIGITS=4, STABLE_CYCLES=4. Hold each digit 8 cycles: digit0=0110000, digit1=0100100, digit2=1111001, digit3=1000000. Expect:
  - value=16'h0123, valid one cycle, err=0, digit_bad=0;
  - valid occurs 5 cycles after digit3 is first driven.
- Digit1 glitches: held 3 cycles, then a different pattern for 1 cycle, then 2 correct cycles. Expect no capture. Only a subsequent 4-cycle stable window captures it; the final value reflects that window.
- All 16 codes cycled through digit0 (NUM_DIGITS=1, STABLE_CYCLES=1). Expect 16 valid pulses with value=0..F in order. Then blank 1111111 gives value=0, err=1, digit_bad=1.
- dig_n=4'b0000 or 4'b1111 for 20 cycles with any seg_n. Expect no capture and no valid.
- Reset asserted after digits 0–2 are captured, then digits 0–3 are redriven with 9, A, b, C. Expect:
  - no valid during or immediately after reset;
  - afterwards, a single valid with value=16'hCBA9 (digit3=C … digit0=9).
- Digit2 captured as 5, then recaptured as 7 before digit3 arrives. Expect nibble 2 of value = 7.
